// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared register map, bit positions and defaults for the input port
package io_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;

    localparam logic [3:0] OFF_SW     = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_ENABLE_BIT  = 1;
    localparam int STATUS_BTN_BIT     = 2;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_ENABLE_BIT = 1;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - two-flop synchronizer plus stability-counter debouncer for a WIDTH-bit group
module io_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;

    // Any bit moving restarts qualification of the whole group.
    always_comb begin
        cnt_next = cnt;
        if (sync2 != prev) begin
            cnt_next = '0;
        end else if (cnt != CW'(CYCLES)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Loading on the edge the counter reaches CYCLES gives CYCLES+3 edges raw-to-output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
            deb   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_next;
            if (cnt_next == CW'(CYCLES)) begin
                deb <= sync2;
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - debounced switch/button input port with a memory-mapped interrupt window
module io_input_port
    import io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [15:0] sw_deb;
    logic        btn_deb;
    logic        btn_deb_q;
    logic        pending;
    logic        enable;
    logic        in_window;
    logic        ctrl_wr;
    logic        btn_rise;
    logic        unused_wdata;

    io_debounce #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk    (clk),
        .resetn (resetn),
        .raw    (sw_raw),
        .deb    (sw_deb)
    );

    io_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk    (clk),
        .resetn (resetn),
        .raw    (btn_raw),
        .deb    (btn_deb)
    );

    assign in_window    = (addr[31:4] == BASE_ADDR[31:4]);
    assign ctrl_wr      = we && in_window && (addr[3:0] == OFF_CTRL);
    assign btn_rise     = btn_deb && !btn_deb_q;
    assign unused_wdata = ^wdata[31:2];

    // A press edge on the same cycle as a clear keeps the interrupt pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_deb_q <= 1'b0;
            pending   <= 1'b0;
            enable    <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_rise) begin
                pending <= 1'b1;
            end else if (ctrl_wr && wdata[CTRL_CLEAR_BIT]) begin
                pending <= 1'b0;
            end
            if (ctrl_wr) begin
                enable <= wdata[CTRL_ENABLE_BIT];
            end
        end
    end

    assign irq = pending & enable;

    always_comb begin
        rdata = '0;
        if (in_window) begin
            case (addr[3:0])
                OFF_SW: rdata[15:0] = sw_deb;
                OFF_STATUS: begin
                    rdata[STATUS_PENDING_BIT] = pending;
                    rdata[STATUS_ENABLE_BIT]  = enable;
                    rdata[STATUS_BTN_BIT]     = btn_deb;
                end
                OFF_CTRL: rdata[CTRL_ENABLE_BIT] = enable;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, giving the number of consecutive stable synchronized samples required before a debounced input changes.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, giving the 16-byte-aligned base of the register window.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: CPU clock; all state updates on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous active-low reset.
REQ-006 Port sw_raw, input, 16: board switches, asynchronous to clk and bouncing.
REQ-007 Port btn_raw, input, 1: interrupt push-button, asynchronous to clk and bouncing.
REQ-008 Port addr, input, 32: data-bus byte address from the core.
REQ-009 Port we, input, 1: data-bus write strobe, sampled on the rising edge of clk.
REQ-010 Port wdata, input, 32: data-bus write data.
REQ-011 Port rdata, output, 32: data-bus read data, combinational from addr and internal registers.
REQ-012 Port irq, output, 1: level interrupt request to the core pause input.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-014 Per debounced group (16-bit switch vector, 1-bit button): a stability counter SHALL clear on any cycle where the synchronized value differs from its previous-cycle sample, and SHALL otherwise increment, saturating at DEBOUNCE_CYCLES.
REQ-015 When the counter equals DEBOUNCE_CYCLES, the debounced register SHALL load the synchronized value.
REQ-016 Latency: a raw input change held steady SHALL appear on the debounced register after exactly DEBOUNCE_CYCLES+3 rising edges.
REQ-017 A change on any single switch bit SHALL restart the debounce for the whole switch vector.
REQ-018 A 0->1 transition of the debounced button SHALL set the pending flag on the next rising edge.
REQ-019 The register window is decoded as addr[31:4] == BASE_ADDR[31:4]; outside the window, rdata SHALL be 0 and writes SHALL be ignored.
REQ-020 Offset 0x0, SW, read-only: rdata = {16'b0, debounced switches}.
REQ-021 Offset 0x4, STATUS, read-only: bit0 pending, bit1 enable, bit2 debounced button level, other bits 0.
REQ-022 Offset 0x8, CTRL: writing bit0=1 SHALL clear pending (write-1-to-clear); every write SHALL load enable from bit1; reads return {30'b0, enable, 1'b0}.
REQ-023 Offset 0xC SHALL read 0; writes to offsets 0x0, 0x4 and 0xC SHALL have no effect.
REQ-024 irq SHALL equal pending AND enable, driven from registers with no combinational path from bus inputs.
REQ-025 If a pending set and a CTRL clear occur on the same edge, pending SHALL be 1 after that edge (set wins).
REQ-026 A button held high SHALL set pending only once; re-arming SHALL require a debounced release followed by a new debounced press.
REQ-027 Each stability counter SHALL be wide enough to hold DEBOUNCE_CYCLES without wrap-around.

Reset
REQ-028 While resetn is 0: synchronizers, previous-sample registers, counters, debounced switches, debounced button, pending and enable SHALL all be 0, irq SHALL be 0, and SW/STATUS/CTRL SHALL read 0.
REQ-029 Assertion of resetn mid-debounce SHALL abort the debounce; after release, the input SHALL requalify from a counter value of 0.

Structure
REQ-030 A shared package io_pkg SHALL hold the register offsets (SW, STATUS, CTRL), the STATUS/CTRL bit positions and the default DEBOUNCE_CYCLES.
REQ-031 A sub-module io_debounce (parameters WIDTH and CYCLES; containing the synchronizer, previous-sample register, counter and debounced register) SHALL be instantiated twice: WIDTH=16 for the switches and WIDTH=1 for the button.

Verification (bench uses DEBOUNCE_CYCLES=4, BASE_ADDR=32'h1000)
REQ-032 Reset, then sw_raw=16'hA5A5 held -> SW read is 0 through edge 6 and 32'h0000_A5A5 after edge 7.
REQ-033 sw_raw toggled every 3 cycles for 40 cycles -> SW value never changes.
REQ-034 Write CTRL=2, then btn_raw held high -> pending=1 and irq=1 after edge 8; STATUS=32'h7.
REQ-035 Write CTRL=3 on the same edge that pending would set -> pending stays 1; a later CTRL=3 write -> irq=0; button still held -> no re-set.
REQ-036 Assert resetn=0 on edge 5 of a pending qualification -> irq=0 and STATUS=0; after release, the held button sets pending 8 edges later.
REQ-037 Read at addr 32'h2000 and write to 32'h1004 -> rdata=0, and no register changes.
